multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Sequencing control unit for the multi-cycle RV32I datapath; it supersedes the single-cycle combinational decoder. It is an FSM that steps each instruction through fetch, decode, execute, memory and writeback. Memory accesses use a variable-latency ready handshake with an optional stall timeout. ECALL is reported to the datapath, which may halt the core.

## Interface
- WAIT_LIMIT, 0: maximum consecutive stall cycles on `mem_ready` before a timeout halt; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.
- clk  in  1  core clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  7  inst[6:0] from the instruction register.
- bcond  in  1  branch-taken flag from the ALU, valid in EX.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- halt_req  in  1  sampled when is_call is high; 1 means halt.
- ir_write, pc_write, i_or_d, mem_read, mem_write, mem_to_reg, write_enable, pc_to_reg, is_call  out  1 each  datapath controls.
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  0 = rs2, 1 = imm, 2 = constant 4.
- alu_op  out  2  0 = add, 1 = branch compare, 2 = funct-decoded.
- pc_source  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit 0 cleared.
- halted, mem_timeout, illegal_op  out  1 each  status flags.
- cycle_cnt, instret_cnt  out  CNT_W each  performance counters.

## Operation
- States: INIT, IF, ID, EX, MEM, WB, HALT.
- All outputs are decoded from the state register and the opcode. Every output not listed for a state is 0.
- INIT: this is the reset state; all outputs are 0. Next state is IF.
- IF: i_or_d=0, mem_read=1. Stays in IF while mem_ready=0. When mem_ready=1: ir_write=1 and next state is ID.
- ID (decode):
  - ECALL (1110011): is_call=1. If halt_req=1, next state is HALT. Otherwise pc_write=1, pc_source=0, next state is IF.
  - Unknown opcode: illegal_op pulses for 1 cycle; pc_write=1, pc_source=0, next state is IF (treated as a NOP).
  - All other valid opcodes: next state is EX.
- EX:
  - R-type (0110011): alu_src_a=1, alu_src_b=0, alu_op=2. Next state is WB.
  - I-type (0010011): alu_src_a=1, alu_src_b=1, alu_op=2. Next state is WB.
  - LOAD/STORE (0000011/0100011): alu_src_a=1, alu_src_b=1, alu_op=0. Next state is MEM.
  - BRANCH (1100011): alu_src_a=1, alu_src_b=0, alu_op=1, pc_write=1, pc_source = bcond ? 1 : 0. Next state is IF.
  - JAL/JALR (1101111/1100111): alu_src_a = JALR ? 1 : 0, alu_src_b=1, alu_op=0. Next state is WB.
- MEM: i_or_d=1; mem_read=1 for a load, mem_write=1 for a store. Stays in MEM while mem_ready=0. When mem_ready=1:
  - Load: next state is WB.
  - Store: pc_write=1, pc_source=0, next state is IF.
- WB: write_enable=1 and pc_write=1.
  - Load: mem_to_reg=1.
  - JAL: pc_to_reg=1, pc_source=1.
  - JALR: pc_to_reg=1, pc_source=2.
  - All others: pc_source=0.
  - Next state is IF.
- The ALU operand selects are held for the whole MEM/WB residency of the instruction.
- HALT: halted=1; all other controls are 0. HALT is sticky until reset.
- Stall timeout (WAIT_LIMIT>0): a wait counter increments on every IF/MEM cycle with mem_ready=0. It clears on mem_ready=1 and on any state change. When the counter reaches WAIT_LIMIT, mem_timeout is set (sticky) and the next state is HALT. No write strobes are issued on that edge.

## Timing
- Reset: state=INIT; wait counter, flags and counters are 0; every output is 0 while reset_n is low.
- Reset asserted mid-instruction aborts the instruction immediately. No pc_write or write_enable pulse follows.
- Latency with zero-wait memory (mem_ready=1 on the first cycle):
  - BRANCH: 3 cycles.
  - R-type, I-type, STORE, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - ECALL and illegal opcodes: 2 cycles.
- Each mem_ready wait cycle adds exactly 1 cycle.
- Exactly one pc_write pulse per retired instruction; it marks the final cycle of that instruction.
- mem_ready is ignored outside IF and MEM.

## Configuration
- CU_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle the state is not INIT or HALT.
  - instret_cnt increments on every pc_write cycle.
  - Both counters wrap modulo 2^CNT_W.
- CU_PERF_CNT_EN undefined: cycle_cnt and instret_cnt are constant 0 and no counter flops are instantiated.

## Structure
- Package cu_pkg holds:
  - opcode localparams;
  - the state enum;
  - encodings for pc_source, alu_src_b and alu_op.
- Sub-module cu_perf_counters (CNT_W) holds the two counters. It is instantiated only under CU_PERF_CNT_EN.

## Test plan
- Reset release; R-type (0110011), mem_ready=1: states INIT, IF, ID, EX, WB. write_enable=1 and pc_write=1 only in WB, pc_source=0. instret_cnt=1.
- LOAD with mem_ready low for 3 MEM cycles: mem_read held for 4 MEM cycles, then WB with mem_to_reg=1. Total 8 cycles.
- BRANCH with bcond=1, then bcond=0: pc_source=1, then 0, each in EX. No write_enable pulse.
- JALR: WB shows pc_to_reg=1, pc_source=2, alu_src_a=1.
- ECALL with halt_req=1: is_call=1 in ID, then halted=1, and cycle_cnt freezes. Opcode 1111111 produces an illegal_op pulse and pc_write with pc_source=0.
- WAIT_LIMIT=4, mem_ready held 0 in IF: mem_timeout=1 and HALT after the 4th stall cycle. Asserting reset_n=0 mid-MEM clears all outputs within the same cycle.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, FSM states and datapath select encodings shared by multicycle_control_unit
package cu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    typedef enum logic [2:0] {
        S_INIT,
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_BR    = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    function automatic logic is_valid_op(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL};
    endfunction

endpackage

// File: rtl/cu_perf_counters.sv
// cu_perf_counters: wrapping cycle and retired-instruction counters, built only with CU_PERF_CNT_EN
`ifdef CU_PERF_CNT_EN
module cu_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cycle_en,
    input  logic             instret_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    // Both counters advance on their enables and wrap naturally at 2^CNT_W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + CNT_W'(cycle_en);
            instret_cnt <= instret_cnt + CNT_W'(instret_en);
        end
    end

endmodule
`endif

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multi-cycle sequencer with ready handshake, stall timeout; counters under CU_PERF_CNT_EN
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             write_enable,
    output logic             pc_to_reg,
    output logic             is_call,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             halted,
    output logic             mem_timeout,
    output logic             illegal_op,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t      state, next_state;
    logic [31:0] wait_cnt;
    logic        timeout_q;
    logic        stalling, timeout_hit, in_alu;
    logic        is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr;

    assign is_r      = opcode == OP_R;
    assign is_i      = opcode == OP_I;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_branch = opcode == OP_BRANCH;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;

    assign stalling    = (state == S_IF || state == S_MEM) && !mem_ready;
    assign timeout_hit = (WAIT_LIMIT > 0) && stalling && wait_cnt == 32'(WAIT_LIMIT - 1);
    assign in_alu      = state == S_EX || state == S_MEM || state == S_WB;
    assign halted      = state == S_HALT;
    assign mem_timeout = timeout_q;

    // State register, consecutive-stall counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_INIT;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= next_state;
            wait_cnt  <= (stalling && next_state == state) ? wait_cnt + 32'd1 : '0;
            timeout_q <= timeout_q | timeout_hit;
        end
    end

    // Next state and datapath controls; ALU selects stay valid from EX through WB
    always_comb begin
        next_state   = state;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        write_enable = 1'b0;
        pc_to_reg    = 1'b0;
        is_call      = 1'b0;
        illegal_op   = 1'b0;
        pc_source    = PC_PLUS4;
        alu_src_a    = in_alu && !is_jal;
        alu_src_b    = (!in_alu || is_r || is_branch) ? SRC_B_RS2 : SRC_B_IMM;
        alu_op       = !in_alu ? ALU_ADD : (is_r || is_i) ? ALU_FUNCT : is_branch ? ALU_BR : ALU_ADD;
        case (state)
            S_INIT: next_state = S_IF;
            S_IF: begin
                mem_read   = 1'b1;
                ir_write   = mem_ready;
                next_state = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                if (opcode == OP_ECALL) begin
                    is_call    = 1'b1;
                    pc_write   = !halt_req;
                    next_state = halt_req ? S_HALT : S_IF;
                end else if (!is_valid_op(opcode)) begin
                    illegal_op = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_IF;
                end else begin
                    next_state = S_EX;
                end
            end
            S_EX: begin
                pc_write   = is_branch;
                pc_source  = (is_branch && bcond) ? PC_IMM : PC_PLUS4;
                next_state = is_branch ? S_IF : (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                i_or_d     = 1'b1;
                mem_read   = is_load;
                mem_write  = !is_load;
                pc_write   = mem_ready && !is_load;
                next_state = !mem_ready ? S_MEM : is_load ? S_WB : S_IF;
            end
            S_WB: begin
                write_enable = 1'b1;
                pc_write     = 1'b1;
                mem_to_reg   = is_load;
                pc_to_reg    = is_jal || is_jalr;
                pc_source    = is_jal ? PC_IMM : is_jalr ? PC_ALU : PC_PLUS4;
                next_state   = S_IF;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_INIT;
        endcase
        if (timeout_hit) next_state = S_HALT;
    end

`ifdef CU_PERF_CNT_EN
    cu_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk         (clk),
        .reset_n     (reset_n),
        .cycle_en    (state != S_INIT && state != S_HALT),
        .instret_en  (pc_write),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: per-instruction trace model checks of multicycle_control_unit (CU_PERF_CNT_EN aware)
module tb_multicycle_control_unit;

    localparam int WL = 4;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, ECALL = 7'b1110011;

    typedef struct packed {
        logic irw, pcw, iod, mrd, mwr, m2r, we, p2r, call, asa;
        logic [1:0] asb, aop, psrc;
        logic hlt, mto, ill;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  opcode = '0;
    logic        bcond = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
    logic        ir_write, pc_write, i_or_d, mem_read, mem_write, mem_to_reg, write_enable, pc_to_reg, is_call;
    logic        alu_src_a, halted, mem_timeout, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [31:0] cycle_cnt, instret_cnt;
    ctl_t        obs;

    int          checks = 0, errors = 0;
    logic [31:0] exp_cyc = '0, exp_ret = '0;
    logic        exp_mto = 1'b0;

    multicycle_control_unit #(.WAIT_LIMIT(WL), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
        .halt_req(halt_req), .ir_write(ir_write), .pc_write(pc_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .write_enable(write_enable), .pc_to_reg(pc_to_reg), .is_call(is_call),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .halted(halted), .mem_timeout(mem_timeout), .illegal_op(illegal_op),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    assign obs = {ir_write, pc_write, i_or_d, mem_read, mem_write, mem_to_reg, write_enable, pc_to_reg,
                  is_call, alu_src_a, alu_src_b, alu_op, pc_source, halted, mem_timeout, illegal_op};

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit known(input logic [6:0] op);
        return op inside {R, I, LD, ST, BR, JAL, JALR, ECALL};
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef CU_PERF_CNT_EN
        chk({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'(exp_cyc));
        chk({tag, " instret_cnt"}, 64'(instret_cnt), 64'(exp_ret));
`else
        chk({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'd0);
        chk({tag, " instret_cnt"}, 64'(instret_cnt), 64'd0);
`endif
    endtask

    // one clock cycle: drive at posedge+1, check at negedge, update model, return at next posedge+1
    task automatic cyc(input string tag, input logic mr, input logic bc, input logic hr, input ctl_t e, input bit active);
        mem_ready = mr;
        bcond     = bc;
        halt_req  = hr;
        e.mto     = exp_mto;
        @(negedge clk);
        chk({tag, " ctl"}, 64'(obs), 64'(e));
        chk_cnt(tag);
        if (active) exp_cyc++;
        if (e.pcw) exp_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, " reset ctl"}, 64'(obs), 64'd0);
        chk({tag, " reset cycle_cnt"}, 64'(cycle_cnt), 64'd0);
        chk({tag, " reset instret_cnt"}, 64'(instret_cnt), 64'd0);
        exp_cyc = '0;
        exp_ret = '0;
        exp_mto = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc({tag, " INIT"}, rb(), rb(), rb(), '0, 0);
    endtask

    function automatic ctl_t alu_of(input logic [6:0] op);
        ctl_t e = '0;
        e.asa = op != JAL;
        e.asb = (op == R || op == BR) ? 2'd0 : 2'd1;
        e.aop = (op == R || op == I) ? 2'd2 : (op == BR) ? 2'd1 : 2'd0;
        return e;
    endfunction

    // expected trace of one instruction, cycle by cycle, from the instruction-class rules
    task automatic run_instr(input logic [6:0] op, input int if_st, input int mem_st, input logic bc, input logic hr);
        ctl_t e;
        opcode = op;
        for (int k = 0; k < if_st; k++) begin
            e = '0; e.mrd = 1'b1;
            cyc("IF stall", 1'b0, rb(), rb(), e, 1);
        end
        e = '0; e.mrd = 1'b1; e.irw = 1'b1;
        cyc("IF", 1'b1, rb(), rb(), e, 1);
        e = '0;
        if (op == ECALL) begin
            e.call = 1'b1;
            e.pcw  = !hr;
            cyc("ID ecall", rb(), rb(), hr, e, 1);
            return;
        end
        if (!known(op)) begin
            e.ill = 1'b1;
            e.pcw = 1'b1;
            cyc("ID illegal", rb(), rb(), rb(), e, 1);
            return;
        end
        cyc("ID", rb(), rb(), rb(), e, 1);
        e = alu_of(op);
        if (op == BR) begin
            e.pcw  = 1'b1;
            e.psrc = bc ? 2'd1 : 2'd0;
            cyc("EX branch", rb(), bc, rb(), e, 1);
            return;
        end
        cyc("EX", rb(), rb(), rb(), e, 1);
        if (op == LD || op == ST) begin
            e = alu_of(op);
            e.iod = 1'b1;
            e.mrd = op == LD;
            e.mwr = op == ST;
            for (int k = 0; k < mem_st; k++) cyc("MEM stall", 1'b0, rb(), rb(), e, 1);
            e.pcw = op == ST;
            cyc("MEM", 1'b1, rb(), rb(), e, 1);
            if (op == ST) return;
        end
        e = alu_of(op);
        e.we   = 1'b1;
        e.pcw  = 1'b1;
        e.m2r  = op == LD;
        e.p2r  = op == JAL || op == JALR;
        e.psrc = (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
        cyc("WB", rb(), rb(), rb(), e, 1);
    endtask

    task automatic halt_cycles(input int n);
        ctl_t e = '0;
        e.hlt = 1'b1;
        for (int k = 0; k < n; k++) cyc("HALT", rb(), rb(), rb(), e, 0);
    endtask

    initial begin
        logic [6:0] ops [9];
        ctl_t       e;
        ops = '{R, I, LD, ST, BR, JAL, JALR, ECALL, 7'b1111111};
        @(posedge clk);
        #1;
        do_reset("por");
        run_instr(R, 0, 0, 0, 0);
        run_instr(LD, 0, 3, 0, 0);
        run_instr(BR, 0, 0, 1, 0);
        run_instr(BR, 0, 0, 0, 0);
        run_instr(JALR, 0, 0, 0, 0);
        run_instr(JAL, 1, 0, 0, 0);
        run_instr(ST, 2, 3, 0, 0);
        run_instr(I, 3, 0, 0, 0);
        run_instr(7'b1111111, 0, 0, 0, 0);
        run_instr(ECALL, 0, 0, 0, 0);
        for (int n = 0; n < 80; n++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb(), 1'b0);
        end
        run_instr(ECALL, 1, 0, 0, 1);
        halt_cycles(5);

        do_reset("timeout");
        opcode = R;
        e = '0; e.mrd = 1'b1;
        for (int k = 0; k < WL; k++) cyc("IF wait", 1'b0, rb(), rb(), e, 1);
        exp_mto = 1'b1;
        halt_cycles(4);

        do_reset("midmem");
        opcode = LD;
        e = '0; e.mrd = 1'b1; e.irw = 1'b1;
        cyc("IF", 1'b1, rb(), rb(), e, 1);
        cyc("ID", rb(), rb(), rb(), '0, 1);
        cyc("EX", rb(), rb(), rb(), alu_of(LD), 1);
        mem_ready = 1'b0;
        #2;
        e = alu_of(LD); e.iod = 1'b1; e.mrd = 1'b1;
        chk("midmem MEM ctl", 64'(obs), 64'(e));
        do_reset("midmem");
        run_instr(R, 0, 0, 0, 0);
        run_instr(ST, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
